clock_btn_repeat_cu: RTL and testbench

- N-channel button command unit for the clock/stopwatch time-set path; sits between the debouncers and the time counters.
- Turns a held, debounced button level into one command pulse, then auto-repeat pulses while the button stays held (fast-set).
- One channel is serviced at a time, with fixed priority, and a post-release gap blocks re-triggers.

---
 rtl/clock_btn_repeat_cu.sv | 127 ++++++++++++
 tb/tb_clock_btn_repeat_cu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/clock_btn_repeat_cu.sv
// Button command unit: one pulse per press, then auto-repeat while held, fixed-priority channel select.
// Latency: button sampled high at edge k -> command pulse in the cycle right after edge k.
// Backpressure: none; presses arriving while busy or during the post-release gap are dropped.
module clock_btn_repeat_cu #(
  parameter int N_BTN         = 3,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int GAP_CYCLES    = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic             o_repeat,
  output logic             o_busy
);

  // One shared counter serves HOLD, REPEAT and GAP, so it is sized for the longest interval.
  localparam int CNT_MAX_HR = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_HR > GAP_CYCLES) ? CNT_MAX_HR : GAP_CYCLES;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SEL_W      = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_HOLD,
    S_REPEAT,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;

  logic [SEL_W-1:0] w_low_idx;
  logic             w_sel_held;
  logic             w_pulse;
  logic [N_BTN-1:0] w_onehot;

  // Lowest pressed index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    w_low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (i_btn[i]) begin
        w_low_idx = SEL_W'(i);
      end
    end
  end

  assign w_sel_held = i_btn[r_sel];

  // Main FSM; the counter restarts from zero on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
    end else if (!i_en) begin
      // Disable wins over everything; a still-held button re-triggers once enabled again.
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (|i_btn) begin
            r_sel   <= w_low_idx;
            r_state <= S_PRESS;
          end
        end
        S_PRESS: begin
          r_state <= S_HOLD;
          r_cnt   <= '0;
        end
        S_HOLD: begin
          if (!w_sel_held) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state <= S_REPEAT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!w_sel_held) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else if (r_cnt == REP_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          // Buttons are deliberately not looked at here: this is the re-trigger lockout.
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Moore decode of the pulse, gated by enable so a disable silences outputs in the same cycle.
  assign w_pulse  = i_en & ((r_state == S_PRESS) |
                            ((r_state == S_REPEAT) & (r_cnt == REP_LAST)));
  assign w_onehot = N_BTN'(1) << r_sel;
  assign o_btn    = w_pulse ? w_onehot : '0;
  assign o_repeat = i_en & (r_state == S_REPEAT);
  assign o_busy   = i_en & (r_state != S_IDLE);

endmodule

// File: tb/tb_clock_btn_repeat_cu.sv
// Directed bench for clock_btn_repeat_cu with short hold/repeat/gap intervals.
// Inputs change 2 time units after a rising edge; outputs are checked at that same offset.
// Expected pulse times are written out by hand relative to the press cycle t0.
module tb_clock_btn_repeat_cu;

  logic       clk;
  logic       rst;
  logic       i_en;
  logic [2:0] i_btn;
  logic [2:0] o_btn;
  logic       o_repeat;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  clock_btn_repeat_cu #(
    .N_BTN        (3),
    .HOLD_CYCLES  (4),
    .REPEAT_CYCLES(3),
    .GAP_CYCLES   (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_en),
    .i_btn   (i_btn),
    .o_btn   (o_btn),
    .o_repeat(o_repeat),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_btn, input logic e_rep,
                         input logic e_busy);
    chk({tag, " btn"}, 32'(o_btn), 32'(e_btn));
    chk({tag, " rep"}, 32'(o_repeat), 32'(e_rep));
    chk({tag, " busy"}, 32'(o_busy), 32'(e_busy));
  endtask

  initial begin
    rst   = 1'b1;
    i_en  = 1'b1;
    i_btn = 3'b000;
    #3;
    chk_all("reset", 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all("post_reset", 3'b000, 1'b0, 1'b0);

    // Tap: two sampled cycles of 001, then release.
    i_btn = 3'b001;
    tick();
    for (int c = 0; c < 7; c++) begin
      chk_all($sformatf("tap c%0d", c), (c == 0) ? 3'b001 : 3'b000, 1'b0, c <= 3);
      if (c == 1) i_btn = 3'b000;
      tick();
    end

    // Hold: 010 held through t0+19, auto-repeat every 3 cycles after the hold window.
    i_btn = 3'b010;
    tick();
    for (int c = 0; c < 24; c++) begin
      logic pulse;
      pulse = (c == 0) || (c == 7) || (c == 10) || (c == 13) || (c == 16) || (c == 19);
      chk_all($sformatf("hold c%0d", c), pulse ? 3'b010 : 3'b000,
              (c >= 5) && (c <= 19), c <= 21);
      if (c == 19) i_btn = 3'b000;
      tick();
    end

    // Priority: 110 together, bit0 added while busy, bit1 released; bit0 fires after the gap.
    i_btn = 3'b110;
    tick();
    for (int c = 0; c < 12; c++) begin
      logic [2:0] eb;
      eb = (c == 0) ? 3'b010 : (c == 7) ? 3'b001 : 3'b000;
      chk_all($sformatf("prio c%0d", c), eb, 1'b0, (c <= 5) || ((c >= 7) && (c <= 10)));
      if (c == 2) i_btn = 3'b111;
      if (c == 3) i_btn = 3'b001;
      if (c == 8) i_btn = 3'b000;
      tick();
    end

    // Enable drop in REPEAT, right on a repeat-pulse cycle.
    i_btn = 3'b100;
    tick();
    for (int c = 0; c < 7; c++) begin
      chk_all($sformatf("endrop c%0d", c), (c == 0) ? 3'b100 : 3'b000, c >= 5, 1'b1);
      tick();
    end
    chk_all("endrop c7 pre", 3'b100, 1'b1, 1'b1);
    i_en = 1'b0;
    #1;
    chk_all("endrop c7 gated", 3'b000, 1'b0, 1'b0);
    tick();
    i_en = 1'b1;
    #1;
    chk_all("endrop idle", 3'b000, 1'b0, 1'b0);
    tick();
    chk_all("endrop repress", 3'b100, 1'b0, 1'b1);
    i_btn = 3'b000;
    for (int c = 0; c < 5; c++) tick();
    chk_all("endrop settle", 3'b000, 1'b0, 1'b0);

    // Early release at HOLD cnt=2; a 100 press during GAP is only taken once IDLE.
    i_btn = 3'b001;
    tick();
    for (int c = 0; c < 8; c++) begin
      logic [2:0] eb;
      eb = (c == 0) ? 3'b001 : (c == 7) ? 3'b100 : 3'b000;
      chk_all($sformatf("early c%0d", c), eb, 1'b0, (c <= 5) || (c == 7));
      if (c == 3) i_btn = 3'b000;
      if (c == 4) i_btn = 3'b100;
      tick();
    end
    i_btn = 3'b000;
    for (int c = 0; c < 6; c++) tick();
    chk_all("early settle", 3'b000, 1'b0, 1'b0);

    // Asynchronous reset mid-HOLD, then re-press with the button still held.
    i_btn = 3'b010;
    tick();
    chk_all("rst t0", 3'b010, 1'b0, 1'b1);
    tick();
    tick();
    chk_all("rst hold", 3'b000, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_all("rst async", 3'b000, 1'b0, 1'b0);
    tick();
    chk_all("rst held", 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("rst repress", 3'b010, 1'b0, 1'b1);
    i_btn = 3'b000;
    for (int c = 0; c < 5; c++) tick();
    chk_all("rst settle", 3'b000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
